seq_pattern_gen: RTL

- Serial pattern transmitter; the driving end of the bit-serial sequence-detector interface.
- On a start request, shifts a fixed PAT_W-bit pattern out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with an optional idle gap between repetitions.
- Used as a stimulus source and link driver for downstream serial detectors.

---
 rtl/seq_gen_pkg.sv | 22 ++
 rtl/seq_down_cnt.sv | 29 ++
 rtl/seq_pattern_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// Purpose: shared types and constants for the serial pattern generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_gen_pkg;

    // Fixed 2-bit state encoding so the state register is easy to recognise in waves.
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_SEND_ENC = 2'd1;
    localparam logic [1:0] ST_GAP_ENC  = 2'd2;
    localparam logic [1:0] ST_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_SEND = ST_SEND_ENC,
        ST_GAP  = ST_GAP_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

    // Default pattern, shifted out MSB-first.
    localparam logic [3:0] DEF_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_down_cnt.sv
// Purpose: generic loadable down-counter with a zero flag; saturates at zero.
// Latency: load/decrement visible one cycle later; zero flag follows the count.
// Backpressure: none; load has priority over decrement.
module seq_down_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Count register: load wins, otherwise step down and stop at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Purpose: serial pattern transmitter, N repeats of PATTERN MSB-first with optional idle gaps; SEQ_GEN_ERRINJ_EN adds err_inj.
// Latency: first bit appears on the same edge that samples start; all outputs registered.
// Backpressure: none; start is only honoured in IDLE, requests while busy are dropped.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SEQ_GEN_ERRINJ_EN
    input  logic             err_inj,
`endif
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_idx
);

    localparam int BIT_W = $clog2(PAT_W);

    state_t state_q, state_d;

    // Next values for the registered outputs.
    logic             out_bit_d, out_valid_d, busy_d, done_d;
    logic [CNT_W-1:0] frame_idx_d;

    // Request parameters captured on the accepted start edge.
    logic             lat_en;
    logic [GAP_W-1:0] gap_q;
    logic             inj;

    // Counter controls.
    logic             bit_load, bit_dec, bit_zero;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic             gap_load, gap_dec, gap_zero;
    logic [GAP_W-1:0] gap_val, gap_cnt;
    logic             frm_load, frm_dec, frm_zero;
    logic [CNT_W-1:0] frm_val, frm_cnt;
    logic             unused_cnt;

    // bit_cnt: index of the bit currently on out_bit.
    seq_down_cnt #(.W(BIT_W)) u_bit_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (bit_load),
        .load_val (BIT_W'(PAT_W - 1)),
        .dec      (bit_dec),
        .cnt      (bit_cnt),
        .zero     (bit_zero)
    );

    // gap_cnt: idle cycles still to go after the current one.
    seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (gap_val),
        .dec      (gap_dec),
        .cnt      (gap_cnt),
        .zero     (gap_zero)
    );

    // frm_cnt: frames still to send after the current one.
    seq_down_cnt #(.W(CNT_W)) u_frm_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (frm_load),
        .load_val (frm_val),
        .dec      (frm_dec),
        .cnt      (frm_cnt),
        .zero     (frm_zero)
    );

    // Only the zero flags of the gap and frame counters drive decisions.
    assign unused_cnt = ^{gap_cnt, frm_cnt};

    assign bit_nxt = bit_cnt - 1'b1;

`ifdef SEQ_GEN_ERRINJ_EN
    logic err_q;

    // Error-injection request is captured alongside the other request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (lat_en) begin
            err_q <= err_inj;
        end
    end

    assign inj = err_q;
`else
    assign inj = 1'b0;
`endif

    // Capture the gap length for the whole request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_q <= '0;
        end else if (lat_en) begin
            gap_q <= gap;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter controls and next output values.
    always_comb begin
        state_d     = state_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        frame_idx_d = frame_idx;
        lat_en      = 1'b0;
        bit_load    = 1'b0;
        bit_dec     = 1'b0;
        gap_load    = 1'b0;
        gap_val     = gap_q - 1'b1;
        gap_dec     = 1'b0;
        frm_load    = 1'b0;
        frm_val     = (repeat_cnt == '0) ? '0 : repeat_cnt - 1'b1;
        frm_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SEND;
                    out_bit_d   = PATTERN[PAT_W-1];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    frame_idx_d = '0;
                    lat_en      = 1'b1;
                    bit_load    = 1'b1;
                    frm_load    = 1'b1;
                end
            end
            ST_SEND: begin
                busy_d = 1'b1;
                if (!bit_zero) begin
                    // Next bit of this frame; the last bit of the last frame may be flipped.
                    bit_dec     = 1'b1;
                    out_valid_d = 1'b1;
                    out_bit_d   = PATTERN[bit_nxt] ^ (inj && frm_zero && (bit_nxt == '0));
                end else if (frm_zero) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (gap_q != '0) begin
                    // Loading gap-1 makes the gap counter hit zero on the final idle cycle.
                    state_d  = ST_GAP;
                    gap_load = 1'b1;
                end else begin
                    out_bit_d   = PATTERN[PAT_W-1];
                    out_valid_d = 1'b1;
                    bit_load    = 1'b1;
                    frm_dec     = 1'b1;
                    frame_idx_d = frame_idx + 1'b1;
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if (gap_zero) begin
                    state_d     = ST_SEND;
                    out_bit_d   = PATTERN[PAT_W-1];
                    out_valid_d = 1'b1;
                    bit_load    = 1'b1;
                    frm_dec     = 1'b1;
                    frame_idx_d = frame_idx + 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output registers; reset clears them immediately, aborting any frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_idx <= '0;
        end else begin
            out_bit   <= out_bit_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
            frame_idx <= frame_idx_d;
        end
    end

endmodule
